decision_unit: RTL and testbench
================================

# decision_unit

Responder to the core controller's decision request. It picks the next branching variable for the bin: on a one-cycle `start_decision_i` pulse it scans the bin's variable-assigned vector from index 0. At the first free variable it raises the decision level and issues a single-cycle write carrying the variable, its saved phase and the new level. It then returns a single-cycle `done_decision_o` pulse. It also owns the current-level register, which the backtrack logic can overwrite.

## Interface
- `NUM_VARS`, default 8: variables per bin; must be ≥ 2.
- `WIDTH_VAR`, default 3: index width; must equal clog2(`NUM_VARS`).
- `WIDTH_LVL`, default 16: decision-level width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start_decision_i` in 1: one-cycle request pulse from the core controller.
- `done_decision_o` out 1: one-cycle completion pulse.
- `no_free_var_o` out 1: qualified by `done_decision_o`; 1 means the scan found no free variable and no write was issued.
- `var_assigned_i` in `NUM_VARS`: bit k = 1 when variable k is assigned.
- `phase_i` in `NUM_VARS`: saved polarity per variable.
- `dcd_we_o` out 1: one-cycle decision-write strobe.
- `dcd_var_o` out `WIDTH_VAR`: decided variable index.
- `dcd_value_o` out 1: value assigned to the decided variable.
- `dcd_lvl_o` out `WIDTH_LVL`: level attached to the decision.
- `cur_lvl_o` out `WIDTH_LVL`: current decision level.
- `lvl_load_i` in 1: load `lvl_i` into the level register (used by backtrack and by the start of a bin).
- `lvl_i` in `WIDTH_LVL`: level value to load.
- `lvl_ovf_o` out 1: sticky flag; an increment was attempted at the maximum level.

## Operation
- States: `IDLE`, `SCAN`, `ASSIGN`, `DONE`. All outputs are registered.
- `IDLE`:
  - `start_decision_i`=1 → scan index ← 0, go to `SCAN`.
  - Otherwise stay.
- `SCAN` (examines one variable per cycle, at index k):
  - `var_assigned_i[k]`=0 → latch k and `phase_i[k]`, go to `ASSIGN`.
  - Otherwise, if k = `NUM_VARS`-1 → set `no_free_var_o`=1, go to `DONE`.
  - Otherwise k ← k+1 and stay in `SCAN`.
- `ASSIGN`, entered for one cycle:
  - `dcd_we_o`=1, `dcd_var_o`=k, `dcd_value_o`=latched phase, `dcd_lvl_o`=L+1, `cur_lvl_o`=L+1, where L is the level before the increment.
  - Always goes to `DONE`.
- `DONE`, one cycle: `done_decision_o`=1, with `no_free_var_o` valid. Next state is `IDLE`.
- `no_free_var_o` clears on the next `start_decision_i`.
- `dcd_var_o`, `dcd_value_o` and `dcd_lvl_o` hold their last values after the strobe.
- Level arithmetic is unsigned, `WIDTH_LVL` bits, and saturates:
  - At the all-ones level, the increment is suppressed and `dcd_lvl_o` reports all-ones.
  - `lvl_ovf_o` is set and stays set until reset.
- Boundary conditions:
  - `start_decision_i` outside `IDLE` is ignored; the protocol forbids it, and the bench checks that it is ignored.
  - `lvl_load_i` is accepted in any state. If it coincides with the `ASSIGN` entry edge, the load wins for `cur_lvl_o`; `dcd_lvl_o` still reports L+1.
  - `var_assigned_i` and `phase_i` are sampled live in each `SCAN` cycle. The requester keeps them stable from the start pulse until done.
  - Reset low at any time: `IDLE` next cycle, scan aborted, no strobe emitted.

## Timing
- Reset values: every output is 0, `cur_lvl_o`=0, `lvl_ovf_o`=0.
- Reference: the start pulse is in cycle 0.
- Free variable at index k:
  - `SCAN` occupies cycles 1 through 1+k.
  - `dcd_we_o` and the new `cur_lvl_o` appear in cycle 2+k.
  - `done_decision_o` appears in cycle 3+k.
  - `IDLE` is reached in cycle 4+k.
  - Latency start → done is 3+k cycles; the minimum is 3.
- No free variable: `done_decision_o`=1 and `no_free_var_o`=1 in cycle `NUM_VARS`+1, with `cur_lvl_o` unchanged.
- Back-to-back: a new start is accepted in the first `IDLE` cycle after `DONE`.
- `lvl_load_i` sampled at an edge → `cur_lvl_o`=`lvl_i` in the next cycle.

## Test plan
- Free-variable decision:
  - Stimulus: reset; load `lvl_i`=0; `var_assigned_i`=8'b0000_0111; `phase_i`=8'b0000_1000; start pulse in cycle 0.
  - Required: `dcd_we_o` in cycle 5 only, with var=3, value=1, `dcd_lvl_o`=1, `cur_lvl_o`=1; done in cycle 6; `no_free_var_o`=0.
- All variables assigned:
  - Stimulus: `var_assigned_i`=8'hFF, `cur_lvl_o`=4, start.
  - Required: no `dcd_we_o`; `done_decision_o` and `no_free_var_o` in cycle 9; `cur_lvl_o` stays 4.
- Minimum latency and back-to-back:
  - Stimulus: `var_assigned_i`=0, start; restart in the first `IDLE` cycle.
  - Required: done in cycle 3; second decision gives `dcd_lvl_o`=2, var=0, done 4 cycles after the first done.
- Level load and collision:
  - Stimulus: load 7 while `IDLE`; then a start whose `ASSIGN` entry edge coincides with `lvl_load_i`=2.
  - Required: `dcd_lvl_o`=8, `cur_lvl_o`=2 afterwards.
- Saturation:
  - Stimulus: load 16'hFFFF, start with a free variable.
  - Required: `dcd_lvl_o`=16'hFFFF, `cur_lvl_o`=16'hFFFF, `lvl_ovf_o`=1 and sticky.
- Reset mid-scan and ignored start:
  - Stimulus: `var_assigned_i`=8'h7F, start; `rst`=0 in cycle 4.
  - Required: no strobe, no done, all outputs 0.
  - Second stimulus: start pulses repeated during `SCAN` of an otherwise normal decision.
  - Required: exactly one done.

Source files
------------

// File: rtl/decision_unit.sv
// decision_unit: picks the first free variable of the bin, emits one decision
// write at the next level and owns the saturating current-level register.
// Ports:
//   clk, rst (sync, active-low)
//   start_decision_i -> done_decision_o, no_free_var_o
//   var_assigned_i, phase_i  : per-variable state of the bin
//   dcd_we_o, dcd_var_o, dcd_value_o, dcd_lvl_o : decision write
//   cur_lvl_o, lvl_load_i, lvl_i, lvl_ovf_o     : level register
module decision_unit #(
  parameter int unsigned NUM_VARS  = 8,
  parameter int unsigned WIDTH_VAR = 3,
  parameter int unsigned WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_decision_i,
  output logic                 done_decision_o,
  output logic                 no_free_var_o,
  input  logic [NUM_VARS-1:0]  var_assigned_i,
  input  logic [NUM_VARS-1:0]  phase_i,
  output logic                 dcd_we_o,
  output logic [WIDTH_VAR-1:0] dcd_var_o,
  output logic                 dcd_value_o,
  output logic [WIDTH_LVL-1:0] dcd_lvl_o,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  input  logic                 lvl_load_i,
  input  logic [WIDTH_LVL-1:0] lvl_i,
  output logic                 lvl_ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ASSIGN,
    DONE
  } state_t;

  localparam logic [WIDTH_VAR-1:0] LAST =
    WIDTH_VAR'(NUM_VARS - 1);
  localparam logic [WIDTH_LVL-1:0] LVL_MAX = '1;

  state_t               state_q, state_d;
  logic [WIDTH_VAR-1:0] idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 nfv_q, nfv_d;
  logic                 we_q, we_d;
  logic [WIDTH_VAR-1:0] var_q, var_d;
  logic                 val_q, val_d;
  logic [WIDTH_LVL-1:0] dlvl_q, dlvl_d;
  logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic                 ovf_q, ovf_d;

  logic                 lvl_sat;
  logic [WIDTH_LVL-1:0] lvl_inc;

  // Saturating increment: at all-ones the level sticks.
  assign lvl_sat = (lvl_q == LVL_MAX);
  assign lvl_inc = lvl_sat ? lvl_q : lvl_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    nfv_d   = nfv_q;
    var_d   = var_q;
    val_d   = val_q;
    dlvl_d  = dlvl_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_decision_i) begin
          idx_d   = '0;
          nfv_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!var_assigned_i[idx_q]) begin
          // Outputs are registered, so the write is
          // formed on the edge that enters ASSIGN.
          state_d = ASSIGN;
          we_d    = 1'b1;
          var_d   = idx_q;
          val_d   = phase_i[idx_q];
          dlvl_d  = lvl_inc;
          lvl_d   = lvl_inc;
          if (lvl_sat) ovf_d = 1'b1;
        end else if (idx_q == LAST) begin
          nfv_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ASSIGN: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // An external load overrides the increment for
    // the level register only; dcd_lvl keeps L+1.
    if (lvl_load_i) lvl_d = lvl_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      nfv_q   <= 1'b0;
      we_q    <= 1'b0;
      var_q   <= '0;
      val_q   <= 1'b0;
      dlvl_q  <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      nfv_q   <= nfv_d;
      we_q    <= we_d;
      var_q   <= var_d;
      val_q   <= val_d;
      dlvl_q  <= dlvl_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign done_decision_o = done_q;
  assign no_free_var_o   = nfv_q;
  assign dcd_we_o        = we_q;
  assign dcd_var_o       = var_q;
  assign dcd_value_o     = val_q;
  assign dcd_lvl_o       = dlvl_q;
  assign cur_lvl_o       = lvl_q;
  assign lvl_ovf_o       = ovf_q;

endmodule

// File: tb/tb_decision_unit.sv
// tb_decision_unit: directed vectors for decision_unit
// with hand-computed cycle timing and levels.
module tb_decision_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        nfv;
  logic [7:0]  va = '0;
  logic [7:0]  ph = '0;
  logic        we;
  logic [2:0]  dvar;
  logic        dval;
  logic [15:0] dlvl;
  logic [15:0] cur;
  logic        lvl_load = 1'b0;
  logic [15:0] lvl_in = '0;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  decision_unit #(
    .NUM_VARS (8),
    .WIDTH_VAR(3),
    .WIDTH_LVL(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_decision_i(start),
    .done_decision_o (done),
    .no_free_var_o   (nfv),
    .var_assigned_i  (va),
    .phase_i         (ph),
    .dcd_we_o        (we),
    .dcd_var_o       (dvar),
    .dcd_value_o     (dval),
    .dcd_lvl_o       (dlvl),
    .cur_lvl_o       (cur),
    .lvl_load_i      (lvl_load),
    .lvl_i           (lvl_in),
    .lvl_ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    lvl_load = 1'b1;
    lvl_in   = v;
    step();
    lvl_load = 1'b0;
  endtask

  // Runs 16 cycles; cycle 0 is the first start cycle.
  task automatic run(input string tag,
                     input logic [15:0] smask,
                     input int ld_cyc,
                     input logic [15:0] ld_val,
                     input int e_nwe,
                     input int e_wecyc,
                     input int e_var,
                     input int e_val,
                     input int e_dlvl,
                     input int e_curw,
                     input int e_ndone,
                     input int e_d1,
                     input int e_d2,
                     input int e_nfv);
    int nwe = 0;
    int ndone = 0;
    int wecyc = -1;
    int d1 = -1;
    int d2 = -1;
    logic [31:0] var_l = '0;
    logic [31:0] val_l = '0;
    logic [31:0] dl_l = '0;
    logic [31:0] cur_w = '0;
    logic [31:0] nfv_l = '0;
    for (int c = 0; c < 16; c++) begin
      start    = smask[c];
      lvl_load = (c == ld_cyc);
      lvl_in   = ld_val;
      @(negedge clk);
      if (we) begin
        nwe++;
        if (wecyc < 0) begin
          wecyc = c;
          cur_w = 32'(cur);
        end
        var_l = 32'(dvar);
        val_l = 32'(dval);
        dl_l  = 32'(dlvl);
      end
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1    = c;
          nfv_l = 32'(nfv);
        end
        d2 = c;
      end
      step();
    end
    start    = 1'b0;
    lvl_load = 1'b0;
    chk({tag, ".nwe"}, nwe, e_nwe);
    if (e_nwe > 0) begin
      chk({tag, ".we_cyc"}, wecyc, e_wecyc);
      chk({tag, ".var"}, var_l, e_var);
      chk({tag, ".val"}, val_l, e_val);
      chk({tag, ".dlvl"}, dl_l, e_dlvl);
      chk({tag, ".cur_we"}, cur_w, e_curw);
    end
    chk({tag, ".ndone"}, ndone, e_ndone);
    chk({tag, ".done_cyc"}, d1, e_d1);
    if (e_ndone > 1)
      chk({tag, ".done2_cyc"}, d2, e_d2);
    chk({tag, ".nfv"}, nfv_l, e_nfv);
  endtask

  initial begin
    int nwe;
    int ndone;
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst.outs",
        {done, nfv, we, dvar, dval, dlvl, cur, ovf}, '0);
    step();
    rst = 1'b1;
    step();

    // first free variable is 3, phase 1
    load(16'd0);
    va = 8'b0000_0111;
    ph = 8'b0000_1000;
    run("free", 16'h0001, -1, 0,
        1, 5, 3, 1, 1, 1, 1, 6, 0, 0);

    // nothing free: no write, level untouched
    load(16'd4);
    @(negedge clk);
    chk("load4.cur", cur, 16'd4);
    step();
    va = 8'hFF;
    run("full", 16'h0001, -1, 0,
        0, 0, 0, 0, 0, 0, 1, 9, 0, 1);
    chk("full.cur", cur, 16'd4);

    // minimum latency, restart in first IDLE cycle
    load(16'd0);
    va = 8'h00;
    ph = 8'h00;
    run("b2b", 16'h0011, -1, 0,
        2, 2, 0, 0, 2, 1, 2, 3, 7, 0);
    chk("b2b.cur", cur, 16'd2);

    // load colliding with the ASSIGN entry edge
    load(16'd7);
    @(negedge clk);
    chk("load7.cur", cur, 16'd7);
    step();
    ph = 8'h01;
    run("coll", 16'h0001, 1, 16'd2,
        1, 2, 0, 1, 8, 2, 1, 3, 0, 0);
    chk("coll.cur", cur, 16'd2);

    // saturation and sticky overflow
    load(16'hFFFF);
    chk("presat.ovf", ovf, 0);
    run("sat", 16'h0001, -1, 0,
        1, 2, 0, 1, 32'hFFFF, 32'hFFFF, 1, 3, 0, 0);
    chk("sat.ovf", ovf, 1);
    load(16'd0);
    run("sticky", 16'h0001, -1, 0,
        1, 2, 0, 1, 1, 1, 1, 3, 0, 0);
    chk("sticky.ovf", ovf, 1);

    // starts during SCAN are ignored
    va = 8'h0F;
    ph = 8'h10;
    run("spam", 16'h000F, -1, 0,
        1, 6, 4, 1, 2, 2, 1, 7, 0, 0);

    // reset in cycle 4 of a scan
    va    = 8'h7F;
    nwe   = 0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      start = (c == 0);
      rst   = (c != 4);
      @(negedge clk);
      if (we) nwe++;
      if (done) ndone++;
      if (c == 5)
        chk("rstmid.outs",
            {done, nfv, we, dvar, dval, dlvl, cur, ovf},
            '0);
      step();
    end
    start = 1'b0;
    rst   = 1'b1;
    chk("rstmid.nwe", nwe, 0);
    chk("rstmid.ndone", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
